aes_ctr_stream: RTL and testbench

AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

---
 rtl/aes_ctr_stream.sv | 274 +++++++++++++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// AES-128 counter-mode keystream generator: pipelined cipher core, credit-limited output FIFO.
// Define AES_CTR_IDX_EN to add out_idx, the counter value of the block on out_data.

module aes128_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         valid_out,
    output logic [127:0] ciphertext
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the field inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a14, a15, p, inv;
        a2  = gmul(a, a);
        a3  = gmul(a2, a);
        a6  = gmul(a3, a3);
        a12 = gmul(a6, a6);
        a14 = gmul(a12, a2);
        a15 = gmul(a12, a3);
        p   = a15;
        for (int i = 0; i < 4; i++) p = gmul(p, p);
        inv = gmul(p, a14);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < n; i++) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            o[127-32*c -: 8] = last ? a0 : xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = last ? a1 : a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = last ? a2 : a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = last ? a3 : xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o ^ rk;
    endfunction

    logic [127:0] st_r [11];
    logic [127:0] kr_r [10];
    logic [127:0] rk_s [1:10];
    logic [10:0]  v_r;

    // Round keys are expanded on the fly alongside the data as it moves down the pipe
    always_comb begin
        for (int r = 1; r < 11; r++) rk_s[r] = next_key(kr_r[r-1], rcon(r));
    end

    // Valid tokens; clearing them on reset discards every in-flight block
    always_ff @(posedge clk) begin
        if (!rst_n) v_r <= 11'd0;
        else        v_r <= {v_r[9:0], valid_in};
    end

    // Datapath: initial AddRoundKey then ten registered rounds
    always_ff @(posedge clk) begin
        st_r[0] <= plaintext ^ key;
        kr_r[0] <= key;
        for (int r = 1; r < 11; r++) st_r[r] <= aes_round(st_r[r-1], rk_s[r], r == 10);
        for (int r = 1; r < 10; r++) kr_r[r] <= rk_s[r];
    end

    assign valid_out  = v_r[10];
    assign ciphertext = st_r[10];
endmodule

module aes_ctr_stream_chk #(
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] fcnt
);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // A push into a full FIFO without a same-cycle pop would overwrite the head
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && (fcnt == FULL)));
    end
endmodule

module aes_ctr_stream #(
    parameter int CTR_W      = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key,
    input  logic [127-CTR_W:0] nonce,
    input  logic [CTR_W-1:0]   ctr_base,
    input  logic [CNT_W-1:0]   count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
`ifdef AES_CTR_IDX_EN
    output logic [CTR_W-1:0]   out_idx,
`endif
    output logic               busy,
    output logic               done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_V = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state_r;
    logic [127:0]        key_r;
    logic [127-CTR_W:0]  nonce_r;
    logic [CTR_W-1:0]    ctr_r;
    logic [CNT_W-1:0]    rem_r;
    logic [CW-1:0]       inflight_r, fcnt_r, fcnt_nxt_s;
    logic [PW-1:0]       wr_r, rd_r;
    logic [127:0]        mem_r [FIFO_DEPTH];
    logic                busy_r, zero_done_r, out_valid_r;
    logic                issue_s, push_s, pop_s, last_pop_s;
    logic [127:0]        ct_s;

    // Credit: issue only while buffered plus in-flight blocks leave room in the FIFO
    assign issue_s    = (state_r == S_RUN) && (({1'b0, fcnt_r} + {1'b0, inflight_r}) < DEPTH_V);
    assign pop_s      = out_valid_r && out_ready;
    assign last_pop_s = (state_r == S_DRAIN) && pop_s && (fcnt_r == ONE_C) && (inflight_r == '0);
    assign fcnt_nxt_s = fcnt_r + CW'(push_s) - CW'(pop_s);

    aes128_encrypt u_core (
        .clk        (clk),
        .rst_n      (~rst),
        .valid_in   (issue_s),
        .plaintext  ({nonce_r, ctr_r}),
        .key        (key_r),
        .valid_out  (push_s),
        .ciphertext (ct_s)
    );

    // Job control FSM and issue bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            zero_done_r <= 1'b0;
            key_r       <= '0;
            nonce_r     <= '0;
            ctr_r       <= '0;
            rem_r       <= '0;
            inflight_r  <= '0;
        end else begin
            zero_done_r <= 1'b0;
            inflight_r  <= inflight_r + CW'(issue_s) - CW'(push_s);
            case (state_r)
                S_IDLE: begin
                    if (start && (count != '0)) begin
                        key_r   <= key;
                        nonce_r <= nonce;
                        ctr_r   <= ctr_base;
                        rem_r   <= count;
                        busy_r  <= 1'b1;
                        state_r <= S_RUN;
                    end else if (start) begin
                        zero_done_r <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue_s) begin
                        ctr_r <= ctr_r + CTR_W'(1);
                        rem_r <= rem_r - CNT_W'(1);
                        if (rem_r == CNT_W'(1)) state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop_s) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Output FIFO; out_valid is kept as a register tracking next-cycle non-empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r        <= '0;
            rd_r        <= '0;
            fcnt_r      <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_r] <= ct_s;
                wr_r        <= wr_r + PW'(1);
            end
            if (pop_s) rd_r <= rd_r + PW'(1);
            fcnt_r      <= fcnt_nxt_s;
            out_valid_r <= (fcnt_nxt_s != '0);
        end
    end

`ifdef AES_CTR_IDX_EN
    logic [CTR_W-1:0] idx_r;

    // Counter value of the FIFO head: job base plus blocks popped so far
    always_ff @(posedge clk) begin
        if (rst)                                               idx_r <= '0;
        else if ((state_r == S_IDLE) && start && (count != '0)) idx_r <= ctr_base;
        else if (pop_s)                                        idx_r <= idx_r + CTR_W'(1);
    end

    assign out_idx = idx_r;
`endif

    aes_ctr_stream_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .fcnt (fcnt_r)
    );

    assign out_valid = out_valid_r;
    assign out_data  = mem_r[rd_r];
    assign busy      = busy_r;
    assign done      = zero_done_r | last_pop_s;
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Self-checking bench for aes_ctr_stream: vector table, random jobs against a table-based AES model.
// Also checks out_idx when AES_CTR_IDX_EN is defined.

module tb_aes_ctr_stream;
    logic         clk = 1'b0;
    logic         rst, start, out_valid, out_ready, busy, done;
    logic [127:0] key, out_data;
    logic [63:0]  nonce, ctr_base;
    logic [31:0]  count;
`ifdef AES_CTR_IDX_EN
    logic [63:0]  out_idx;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] k;
        logic [63:0]  n;
        logic [63:0]  b;
        int           cnt;
        int           stall;
        int           mode;
        bit           has_exp;
        logic [127:0] exp0;
    } vec_t;
    vec_t tbl [8];

    aes_ctr_stream dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .ctr_base(ctr_base),
        .count(count), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_CTR_IDX_EN
        .out_idx(out_idx),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box via log/antilog tables over generator 3
    task automatic build_sbox();
        int exp_t [256];
        int log_t [256];
        logic [7:0] p, inv, s;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = int'(p);
            log_t[p] = i;
            p = p ^ xt(p);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sb[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0]  s [4][4];
        logic [7:0]  t [4][4];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd != 10) begin
                    s[0][c] = xt(t[0][c]) ^ xt(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ xt(t[1][c]) ^ xt(t[2][c]) ^ t[2][c] ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ xt(t[2][c]) ^ xt(t[3][c]) ^ t[3][c];
                    s[3][c] = xt(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xt(t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Run one job, scoring every handshake against the model's counter-ordered stream
    task automatic run_job(input logic [127:0] k, input logic [63:0] n, input logic [63:0] b,
                           input int cnt, input int stall, input int mode,
                           input bit has_exp, input logic [127:0] exp0);
        logic [127:0] expq [$];
        int idx, cyc, first_v, last_pop, dones, budget;
        bit fin;
        for (int i = 0; i < cnt; i++) expq.push_back(aes_ref(k, {n, b + 64'(i)}));
        key = k; nonce = n; ctr_base = b; count = 32'(cnt); start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_on_start", {127'd0, busy}, 128'd1);
        idx = 0; cyc = 0; first_v = -1; last_pop = -1; dones = 0; fin = 1'b0;
        budget = 200 + 4 * cnt + stall;
        while (!fin && cyc < budget) begin
            out_ready = (cyc < stall) ? 1'b0 : ((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            start = busy && ($urandom_range(0, 7) == 0);
            key = {$urandom, $urandom, $urandom, $urandom};
            nonce = {$urandom, $urandom};
            ctr_base = {$urandom, $urandom};
            count = 32'($urandom_range(0, 9));
            #1;
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                if (idx < cnt) chk("out_data", out_data, expq[idx]);
                else chk("extra_output", 128'(idx), 128'(cnt - 1));
                if (idx == 0 && has_exp) chk("known_vector", out_data, exp0);
`ifdef AES_CTR_IDX_EN
                chk("out_idx", {64'd0, out_idx}, {64'd0, b + 64'(idx)});
`endif
                idx++;
                last_pop = cyc;
            end
            if (done) begin
                dones++;
                chk("done_on_last_pop", 128'(idx), 128'(cnt));
                fin = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!fin) chk("job_timeout", 128'(dones), 128'd1);
        chk("first_valid_latency", 128'(first_v), 128'd12);
        if (mode == 0 && stall == 0) chk("throughput", 128'(last_pop - first_v), 128'(cnt - 1));
        chk("busy_after_done", {126'd0, busy, done}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_after_job", {126'd0, out_valid, busy}, 128'd0);
        end
    endtask

    initial begin
        build_sbox();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        key = '0; nonce = '0; ctr_base = '0; count = '0;
        tick(); tick();
        chk("reset_state", {out_data, busy, done, out_valid}, 131'd0);
        rst = 1'b0;
        tick();
        chk("after_reset", {out_data, busy, done, out_valid}, 131'd0);
        chk("model_fips", aes_ref(128'h2b7e151628aed2a6abf7158809cf4f3c,
                                  128'h3243f6a8885a308d313198a2e0370734),
            128'h3925841d02dc09fbdc118597196a0b32);

        tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 64'h3243f6a8885a308d,
                   64'h313198a2e0370734, 1, 0, 0, 1'b1, 128'h3925841d02dc09fbdc118597196a0b32};
        tbl[1] = '{128'h0, 64'h0, 64'h0, 1, 0, 0, 1'b1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 64'h0011223344556677,
                   64'hffffffffffffffff, 2, 0, 0, 1'b0, 128'h0};
        tbl[3] = '{128'h0f0e0d0c0b0a09080706050403020100, 64'hdeadbeefcafef00d,
                   64'h0000000000000010, 100, 50, 0, 1'b0, 128'h0};
        for (int i = 4; i < 8; i++)
            tbl[i] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, int'($urandom_range(1, 40)),
                       int'($urandom_range(0, 20)), 1, 1'b0, 128'h0};

        foreach (tbl[i]) run_job(tbl[i].k, tbl[i].n, tbl[i].b, tbl[i].cnt, tbl[i].stall,
                                 tbl[i].mode, tbl[i].has_exp, tbl[i].exp0);

        // count==0: done the next cycle, busy never rises
        count = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_count_done", {126'd0, done, busy}, 128'd2);
        tick();
        chk("zero_count_after", {126'd0, done, busy}, 128'd0);

        // Reset five cycles into a 20-block job with out_ready low
        key = 128'h1; nonce = 64'h2; ctr_base = 64'h3; count = 32'd20; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_job_reset", {out_data, busy, done, out_valid}, 131'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                out_ready = 1'(i % 2);
                tick();
                seen += int'(out_valid) + int'(busy);
            end
            out_ready = 1'b0;
            chk("no_output_after_reset", 128'(seen), 128'd0);
        end
        run_job(128'h2b7e151628aed2a6abf7158809cf4f3c, 64'h3243f6a8885a308d,
                64'h313198a2e0370734, 5, 0, 1, 1'b1, 128'h3925841d02dc09fbdc118597196a0b32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
